// File: rtl/dp_ram_param.sv
// Parametrised single-clock true dual-port RAM with reset-time clear sweep,
// per-port read-valid strobes and same-address dual-write collision flag.

// Per-port read pipeline: one stage for the registered array read, plus an
// optional output register. Data stages only load on a valid beat, so the
// last completed read stays on dout.
module dp_ram_rd_port #(
  parameter int DATA_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic              clk0,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              vld_o
);
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  logic [STAGES:1]   vld_pipe;
  logic [DATA_W-1:0] dat_pipe [STAGES:1];

  // Valid shift register with data stages that capture only on valid beats
  always_ff @(posedge clk0) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int s = 1; s <= STAGES; s++) dat_pipe[s] <= '0;
    end else begin
      vld_pipe[1] <= rd_en_i;
      if (rd_en_i) dat_pipe[1] <= rd_data_i;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign dout_o = dat_pipe[STAGES];
  assign vld_o  = vld_pipe[STAGES];
endmodule

module dp_ram_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk0,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              we_a,
  input  logic              re_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              vld_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              we_b,
  input  logic              re_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              vld_b,
  output logic              collision,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic                busy_q;
  logic                collision_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                run;
  logic                same_wr;
  logic [DATA_W-1:0]   rd_a_d, rd_b_d;

  assign run     = (state_q == RUN);
  assign same_wr = we_a && we_b && (addr_a == addr_b);

  // Clear-sweep FSM; busy and collision are registered alongside the state
  always_ff @(posedge clk0) begin
    if (rst) begin
      state_q     <= (CLR_ON_RST != 0) ? CLEAR : RUN;
      busy_q      <= (CLR_ON_RST != 0);
      clr_addr_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      collision_q <= run && same_wr;
      if (state_q == CLEAR) begin
        clr_addr_q <= clr_addr_q + ADDR_W'(1);
        if (&clr_addr_q) begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  // Array write: sweep zeroes one word per cycle, otherwise port writes with
  // port A taking priority when both ports hit the same word
  always_ff @(posedge clk0) begin
    if (!rst) begin
      if (!run) begin
        mem[clr_addr_q] <= '0;
      end else begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b && !same_wr) mem[addr_b] <= din_b;
      end
    end
  end

  // Read word selection; write-first forwards the word being written, and the
  // A-over-B ordering matches what the array actually stores on a collision
  always_comb begin
    rd_a_d = mem[addr_a];
    rd_b_d = mem[addr_b];
    if (RD_MODE != 0) begin
      if (we_b && addr_b == addr_a) rd_a_d = din_b;
      if (we_a && addr_a == addr_a) rd_a_d = din_a;
      if (we_b && addr_b == addr_b) rd_b_d = din_b;
      if (we_a && addr_a == addr_b) rd_b_d = din_a;
    end
  end

  dp_ram_rd_port #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rd_a (
    .clk0      (clk0),
    .rst       (rst),
    .rd_en_i   (re_a && run),
    .rd_data_i (rd_a_d),
    .dout_o    (dout_a),
    .vld_o     (vld_a)
  );

  dp_ram_rd_port #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rd_b (
    .clk0      (clk0),
    .rst       (rst),
    .rd_en_i   (re_b && run),
    .rd_data_i (rd_b_d),
    .dout_o    (dout_b),
    .vld_o     (vld_b)
  );

  assign collision = collision_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_dp_ram_param.sv
// Bench for dp_ram_param: two instances share one stimulus stream.
//   dut0: read-first, 1-cycle latency, clear on reset
//   dut1: write-first, 2-cycle latency, contents kept over reset
module tb_dp_ram_param;
  logic       clk0 = 1'b0;
  logic       rst;
  logic [7:0] din_a, din_b;
  logic [3:0] addr_a, addr_b;
  logic       we_a, re_a, we_b, re_b;

  logic [7:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic       vld_a0, vld_b0, vld_a1, vld_b1;
  logic       coll0, coll1, busy0, busy1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk0 = ~clk0;

  dp_ram_param #(.DATA_W(8), .ADDR_W(4), .RD_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) dut0 (
    .clk0(clk0), .rst(rst),
    .din_a(din_a), .addr_a(addr_a), .we_a(we_a), .re_a(re_a), .dout_a(dout_a0), .vld_a(vld_a0),
    .din_b(din_b), .addr_b(addr_b), .we_b(we_b), .re_b(re_b), .dout_b(dout_b0), .vld_b(vld_b0),
    .collision(coll0), .busy(busy0)
  );

  dp_ram_param #(.DATA_W(8), .ADDR_W(4), .RD_MODE(1), .OUT_REG(1), .CLR_ON_RST(0)) dut1 (
    .clk0(clk0), .rst(rst),
    .din_a(din_a), .addr_a(addr_a), .we_a(we_a), .re_a(re_a), .dout_a(dout_a1), .vld_a(vld_a1),
    .din_b(din_b), .addr_b(addr_b), .we_b(we_b), .re_b(re_b), .dout_b(dout_b1), .vld_b(vld_b1),
    .collision(coll1), .busy(busy1)
  );

  typedef struct {
    logic       we_a, re_a; logic [3:0] addr_a; logic [7:0] din_a;
    logic       we_b, re_b; logic [3:0] addr_b; logic [7:0] din_b;
    logic [7:0] e0_da; logic e0_va; logic [7:0] e0_db; logic e0_vb; logic e0_c;
    logic [7:0] e1_da; logic e1_va; logic [7:0] e1_db; logic e1_vb; logic e1_c;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(
    input logic wa, ra, input logic [3:0] aa, input logic [7:0] da,
    input logic wb, rb, input logic [3:0] ab, input logic [7:0] db,
    input logic [7:0] x0a, input logic v0a, input logic [7:0] x0b, input logic v0b, input logic c0,
    input logic [7:0] x1a, input logic v1a, input logic [7:0] x1b, input logic v1b, input logic c1);
    vec_t v;
    v.we_a = wa; v.re_a = ra; v.addr_a = aa; v.din_a = da;
    v.we_b = wb; v.re_b = rb; v.addr_b = ab; v.din_b = db;
    v.e0_da = x0a; v.e0_va = v0a; v.e0_db = x0b; v.e0_vb = v0b; v.e0_c = c0;
    v.e1_da = x1a; v.e1_va = v1a; v.e1_db = x1b; v.e1_vb = v1b; v.e1_c = c1;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    we_a = 0; re_a = 0; addr_a = 0; din_a = 0;
    we_b = 0; re_b = 0; addr_b = 0; din_b = 0;
  endtask

  // Release reset and count busy cycles (including the reset-edge cycle).
  // Optionally injects a write to addr 2 on the third busy cycle.
  task automatic sweep(input bit inj, output int nb0, output int nb1, output int nbad);
    nb0  = busy0 ? 1 : 0;
    nb1  = busy1 ? 1 : 0;
    nbad = 0;
    rst  = 0;
    for (int k = 0; k < 40; k++) begin
      if (inj && nb0 == 3) begin we_a = 1; addr_a = 4'd2; din_a = 8'h55; end
      else we_a = 0;
      tick;
      if (dout_a0 !== 8'h00 || vld_a0 !== 1'b0 || dout_b0 !== 8'h00 || vld_b0 !== 1'b0) nbad++;
      if (busy1) nb1++;
      if (busy0) nb0++;
      else break;
    end
    we_a = 0;
  endtask

  task automatic fill(input logic [7:0] val);
    for (int i = 0; i < 16; i++) begin
      we_a = 1; addr_a = 4'(i); din_a = val;
      tick;
    end
    we_a = 0;
  endtask

  // Read every word: A walks up, B walks down. dut0 checked one edge after
  // issue, dut1 one edge later. dut1 addr 2 may hold a distinct value.
  task automatic read_all(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e1_a2);
    logic [3:0] pa, pb;
    for (int i = 0; i <= 16; i++) begin
      re_a = (i < 16); re_b = (i < 16);
      addr_a = 4'(i); addr_b = 4'(15 - i);
      tick;
      if (i < 16) begin
        chk("rd dut0 dout_a", dout_a0, e0); chk("rd dut0 vld_a", vld_a0, 1);
        chk("rd dut0 dout_b", dout_b0, e0); chk("rd dut0 vld_b", vld_b0, 1);
      end
      if (i > 0) begin
        pa = 4'(i - 1); pb = 4'(16 - i);
        chk("rd dut1 dout_a", dout_a1, (pa == 4'd2) ? e1_a2 : e1); chk("rd dut1 vld_a", vld_a1, 1);
        chk("rd dut1 dout_b", dout_b1, (pb == 4'd2) ? e1_a2 : e1); chk("rd dut1 vld_b", vld_b1, 1);
      end
    end
    re_a = 0; re_b = 0;
  endtask

  initial begin
    int nb0, nb1, nbad;
    // we_a re_a aa da | we_b re_b ab db | dut0: da va db vb c | dut1: da va db vb c
    tbl[0]  = mk(1,0,4'hA,8'h01, 0,0,4'h0,8'h00, 8'h00,0,8'h00,0,0, 8'hAA,0,8'hAA,0,0);
    tbl[1]  = mk(0,0,4'h0,8'h00, 0,1,4'hA,8'h00, 8'h00,0,8'h01,1,0, 8'hAA,0,8'hAA,0,0);
    tbl[2]  = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h00,0,8'h01,0,0, 8'hAA,0,8'h01,1,0);
    tbl[3]  = mk(1,0,4'h3,8'h11, 0,0,4'h0,8'h00, 8'h00,0,8'h01,0,0, 8'hAA,0,8'h01,0,0);
    tbl[4]  = mk(1,1,4'h3,8'h22, 0,0,4'h0,8'h00, 8'h11,1,8'h01,0,0, 8'hAA,0,8'h01,0,0);
    tbl[5]  = mk(0,1,4'h3,8'h00, 0,0,4'h0,8'h00, 8'h22,1,8'h01,0,0, 8'h22,1,8'h01,0,0);
    tbl[6]  = mk(1,0,4'hF,8'h33, 0,0,4'h0,8'h00, 8'h22,0,8'h01,0,0, 8'h22,1,8'h01,0,0);
    tbl[7]  = mk(1,0,4'hF,8'h5A, 0,1,4'hF,8'h00, 8'h22,0,8'h33,1,0, 8'h22,0,8'h01,0,0);
    tbl[8]  = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h22,0,8'h33,0,0, 8'h22,0,8'h5A,1,0);
    tbl[9]  = mk(1,0,4'h7,8'hC3, 1,0,4'h7,8'h3C, 8'h22,0,8'h33,0,1, 8'h22,0,8'h5A,0,1);
    tbl[10] = mk(0,1,4'h7,8'h00, 0,1,4'h7,8'h00, 8'hC3,1,8'hC3,1,0, 8'h22,0,8'h5A,0,0);
    tbl[11] = mk(1,0,4'h7,8'hC3, 1,0,4'h8,8'h3C, 8'hC3,0,8'hC3,0,0, 8'hC3,1,8'hC3,1,0);
    tbl[12] = mk(0,1,4'h7,8'h00, 0,1,4'h8,8'h00, 8'hC3,1,8'h3C,1,0, 8'hC3,0,8'hC3,0,0);
    tbl[13] = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'hC3,0,8'h3C,0,0, 8'hC3,1,8'h3C,1,0);
    tbl[14] = mk(1,0,4'h9,8'h66, 1,1,4'h9,8'h99, 8'hC3,0,8'h00,1,1, 8'hC3,0,8'h3C,0,1);
    tbl[15] = mk(0,1,4'h9,8'h00, 0,0,4'h0,8'h00, 8'h66,1,8'h00,0,0, 8'hC3,0,8'h66,1,0);
    tbl[16] = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 8'h66,0,8'h00,0,0, 8'h66,1,8'h66,0,0);

    idle_inputs();
    rst = 1;
    tick; tick;
    chk("reset dout_a", dout_a0, 0); chk("reset vld_a", vld_a0, 0);
    chk("reset dout_b", dout_b0, 0); chk("reset vld_b", vld_b0, 0);
    chk("reset collision", coll0, 0); chk("reset busy dut0", busy0, 1);
    chk("reset busy dut1", busy1, 0); chk("reset vld dut1", {vld_a1, vld_b1}, 0);

    // Power-on sweep, then fill and re-sweep with an injected write
    sweep(0, nb0, nb1, nbad);
    chk("initial busy cycles", nb0, 16);
    fill(8'hAA);
    rst = 1; tick;
    chk("pulse busy dut0", busy0, 1);
    sweep(1, nb0, nb1, nbad);
    chk("sweep busy cycles", nb0, 16);
    chk("dut1 busy cycles", nb1, 0);
    chk("sweep outputs quiet", nbad, 0);
    read_all(8'h00, 8'hAA, 8'h55);
    tick;

    // Latency, read-during-write, cross-port, collision
    for (int i = 0; i < 17; i++) begin
      we_a = tbl[i].we_a; re_a = tbl[i].re_a; addr_a = tbl[i].addr_a; din_a = tbl[i].din_a;
      we_b = tbl[i].we_b; re_b = tbl[i].re_b; addr_b = tbl[i].addr_b; din_b = tbl[i].din_b;
      tick;
      chk($sformatf("v%0d dut0 dout_a", i), dout_a0, tbl[i].e0_da);
      chk($sformatf("v%0d dut0 vld_a", i),  vld_a0,  tbl[i].e0_va);
      chk($sformatf("v%0d dut0 dout_b", i), dout_b0, tbl[i].e0_db);
      chk($sformatf("v%0d dut0 vld_b", i),  vld_b0,  tbl[i].e0_vb);
      chk($sformatf("v%0d dut0 coll", i),   coll0,   tbl[i].e0_c);
      chk($sformatf("v%0d dut1 dout_a", i), dout_a1, tbl[i].e1_da);
      chk($sformatf("v%0d dut1 vld_a", i),  vld_a1,  tbl[i].e1_va);
      chk($sformatf("v%0d dut1 dout_b", i), dout_b1, tbl[i].e1_db);
      chk($sformatf("v%0d dut1 vld_b", i),  vld_b1,  tbl[i].e1_vb);
      chk($sformatf("v%0d dut1 coll", i),   coll1,   tbl[i].e1_c);
    end
    idle_inputs();

    // Reset reasserted mid-sweep while port A keeps requesting reads
    fill(8'hEE);
    rst = 1; re_a = 1; addr_a = 4'd0;
    tick;
    rst = 0;
    nbad = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (dout_a0 !== 8'h00 || vld_a0 !== 1'b0 || busy0 !== 1'b1) nbad++;
    end
    chk("first half sweep", nbad, 0);
    rst = 1;
    tick;
    chk("restart busy", busy0, 1);
    chk("restart dout_a", dout_a0, 0);
    sweep(0, nb0, nb1, nbad);
    chk("restart busy cycles", nb0, 16);
    chk("restart outputs quiet", nbad, 0);
    re_a = 0;
    read_all(8'h00, 8'hEE, 8'hEE);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dp_ram_param.md
Name: dp_ram_param

Overview:
Parametrised single-clock true dual-port RAM; successor to the fixed 16x8 two-port RAM. Width, depth, read latency and read-during-write mode are configurable. Adds a hardware clear sweep on reset, read-valid strobes and dual-write collision flagging. Used as a generic shared buffer between two same-clock masters.

Parameters:
DATA_W, 8, data width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
RD_MODE, 0, 0 = read-first (old data), 1 = write-first (new data) on same-address read/write
OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency
CLR_ON_RST, 1, 1 = zero all words after reset; 0 = contents preserved over reset

Ports:
clk0  in  1  single clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
din_a  in  DATA_W  port A write data
addr_a  in  ADDR_W  port A address
we_a  in  1  port A write enable
re_a  in  1  port A read enable
dout_a  out  DATA_W  port A read data
vld_a  out  1  port A read-data valid strobe
din_b, addr_b, we_b, re_b, dout_b, vld_b: port B, same widths and meanings as port A
collision  out  1  both ports wrote the same address
busy  out  1  clear sweep in progress; port requests ignored

Behaviour:
- Reset (rst sampled high): dout_a/b=0, vld_a/b=0, collision=0, output pipeline regs=0; busy=CLR_ON_RST; sweep counter=0; no memory write in a reset cycle.
- FSM states: CLEAR, RUN. rst high -> CLEAR if CLR_ON_RST=1, else RUN.
- CLEAR: each edge with rst low writes 0 to mem[clr_addr], then clr_addr++. Edge that writes DEPTH-1 -> RUN, busy=0. busy is high for exactly DEPTH cycles after rst release.
- CLEAR: we/re on both ports ignored. No writes, vld stays 0, dout holds 0.
- rst reasserted mid-sweep restarts the sweep at address 0.
- RUN write: we_x at edge -> mem[addr_x]=din_x.
- RUN read: re_x at edge T -> dout_x/vld_x updated at T+1 (OUT_REG=0) or T+2 (OUT_REG=1).
- vld_x is a 1-cycle strobe per read; back-to-back reads give continuous vld.
- dout_x holds its last value when no read completes.
- Same-address read during write (same port or cross-port, same cycle): RD_MODE=0 returns the pre-write word; RD_MODE=1 returns the word being written.
- Dual write, same address: port A wins; mem holds din_a; port B write dropped. collision=1 on the next cycle, one cycle per event. Write-first reads of that address return din_a.
- Dual write, different addresses: both complete, no collision.
- Dual read, same address: both ports get the same data, no collision.
- No out-of-range addresses (DEPTH=2**ADDR_W). All arithmetic is unsigned; clr_addr wraps only at the sweep end.

Test Plan:
(All scenarios DATA_W=8, ADDR_W=4.)
1. Clear sweep: fill all 16 words with 8'hAA (CLR_ON_RST=1), pulse rst one cycle -> busy high exactly 16 cycles. A write of 8'h55 to addr 2 during busy is dropped. Afterwards all 16 reads return 8'h00 with vld. With CLR_ON_RST=0 -> busy stays 0 and reads return 8'hAA.
2. Latency: A writes 8'h01 to 4'hA, next cycle B re on 4'hA -> dout_b=8'h01 and vld_b=1 one cycle after re (OUT_REG=0), two cycles after (OUT_REG=1). vld_b drops the following cycle and dout_b holds 8'h01.
3. Same-port read-during-write: mem[3]=8'h11; A we+re addr 3, din 8'h22 -> dout_a=8'h11 (RD_MODE=0) or 8'h22 (RD_MODE=1). Later read of addr 3 returns 8'h22 in both modes.
4. Cross-port: mem[4'hF]=8'h33; A writes 8'h5A to 4'hF while B reads 4'hF -> dout_b=8'h33 (RD_MODE=0) or 8'h5A (RD_MODE=1).
5. Dual-write collision: A din 8'hC3, B din 8'h3C, both addr 7 -> mem[7]=8'hC3, collision=1 for exactly one cycle. Repeat with B at addr 8 -> mem[7]=8'hC3, mem[8]=8'h3C, collision stays 0.
6. Reset mid-sweep: reassert rst when clr_addr=8 -> sweep restarts at 0, busy high 16 more cycles from rst release. dout/vld are 0 throughout, and all words read 8'h00 afterwards.
